onchip_memory_stream_reader: RTL and testbench

- Avalon-MM read initiator for the single-port on-chip memory slave: 32-bit data, 18-bit word address, fixed 1-cycle read latency, no waitrequest.
- On a start command it reads a contiguous block of words and emits them as an Avalon-ST packet with ready/valid backpressure.
- Sits between the NIOS-programmed control registers and the downstream streaming datapath, for example a SpaceWire/FEE data packetiser.

---
 rtl/onchip_memory_pkg.sv | 15 +
 rtl/stream_sync_fifo.sv | 58 +++++
 rtl/onchip_memory_stream_reader.sv | 176 +++++++++++++++++
 tb/tb_onchip_memory_stream_reader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_memory_pkg.sv
// Shared constants and FSM encoding for the on-chip memory stream reader.
package onchip_memory_pkg;

  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 32;
  localparam int MEM_WORDS  = 212992;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/stream_sync_fifo.sv
// Small synchronous FIFO holding stream beats (data plus sop/eop flags).
// Head entry is visible on pop_data without a read cycle; flush empties it.
module stream_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == CW'(0));
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Pointer and occupancy bookkeeping; flush behaves like a local reset.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents of empty slots are don't-care so no reset needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/onchip_memory_stream_reader.sv
// Avalon-MM read initiator that streams a contiguous block of on-chip memory
// words out as one Avalon-ST packet, with credit-based flow control so the
// output buffer can never overflow while the stream is back-pressured.
module onchip_memory_stream_reader #(
  parameter int ADDR_W     = onchip_memory_pkg::ADDR_W,
  parameter int DATA_W     = onchip_memory_pkg::DATA_W,
  parameter int MEM_WORDS  = onchip_memory_pkg::MEM_WORDS,
  parameter int FIFO_DEPTH = onchip_memory_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic              avm_clken,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  import onchip_memory_pkg::*;

  localparam int CNT_W   = ADDR_W + 1;
  localparam int FCW     = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W   = FCW + 1;
  localparam int ENTRY_W = DATA_W + 2;

  state_e              r_state;
  state_e              w_next_state;
  logic                w_done_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_issue_cnt;
  logic [CNT_W-1:0]    r_out_cnt;
  logic [CNT_W-1:0]    r_length;
  logic                r_inflight;
  logic                r_inflight_sop;
  logic                r_inflight_eop;
  logic                r_done;

  logic                w_busy;
  logic                w_abort;
  logic                w_credit;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [FCW-1:0]      w_fifo_count;
  logic [ENTRY_W-1:0]  w_head;

  assign w_busy  = (r_state != ST_IDLE);
  assign w_abort = abort & w_busy;
  // A read may only go out if its word is guaranteed a FIFO slot on return.
  assign w_credit = (SUM_W'(w_fifo_count) + SUM_W'(r_inflight)) < SUM_W'(FIFO_DEPTH);
  assign w_issue  = (r_state == ST_READ) & ~abort & (r_issue_cnt != CNT_W'(0)) & w_credit;
  assign w_pop    = ~w_empty & st_ready;
  assign w_push   = r_inflight & (~w_full | w_pop);

  stream_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (w_abort),
    .push      (w_push),
    .push_data ({r_inflight_sop, r_inflight_eop, avm_readdata}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done_next;
    end
  end

  // Next-state and done-pulse decode.
  always_comb begin
    w_next_state = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (length != CNT_W'(0)) w_next_state = ST_READ;
          else                     w_done_next  = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_READ: begin
        if (abort) begin
          w_next_state = ST_IDLE;
          w_done_next  = 1'b1;
        end else if (w_issue && (r_issue_cnt == CNT_W'(1))) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_next_state = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (abort || (w_pop && (r_out_cnt == CNT_W'(1)))) begin
          w_next_state = ST_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_done_next  = 1'b0;
      end
    endcase
  end

  // Transfer datapath: address walk, counters and the read-return tag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr         <= ADDR_W'(0);
      r_issue_cnt    <= CNT_W'(0);
      r_out_cnt      <= CNT_W'(0);
      r_length       <= CNT_W'(0);
      r_inflight     <= 1'b0;
      r_inflight_sop <= 1'b0;
      r_inflight_eop <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start && (length != CNT_W'(0))) begin
        r_addr      <= base_addr;
        r_issue_cnt <= length;
        r_out_cnt   <= length;
        r_length    <= length;
      end else begin
        if (w_issue) begin
          r_addr      <= (r_addr == ADDR_W'(MEM_WORDS - 1)) ? ADDR_W'(0) : r_addr + ADDR_W'(1);
          r_issue_cnt <= r_issue_cnt - CNT_W'(1);
        end
        if (w_pop && w_busy) r_out_cnt <= r_out_cnt - CNT_W'(1);
      end
      // Abort suppresses w_issue, so the returning word is never tagged.
      r_inflight     <= w_issue;
      r_inflight_sop <= (r_issue_cnt == r_length);
      r_inflight_eop <= (r_issue_cnt == CNT_W'(1));
    end
  end

  assign busy           = w_busy;
  assign done           = r_done;
  assign avm_address    = r_addr;
  assign avm_chipselect = w_issue;
  assign avm_write      = 1'b0;
  assign avm_byteenable = 4'hF;
  assign avm_clken      = 1'b1;
  assign st_valid       = ~w_empty;
  assign st_data        = w_head[DATA_W-1:0];
  assign st_sop         = ~w_empty & w_head[DATA_W+1];
  assign st_eop         = ~w_empty & w_head[DATA_W];

endmodule

// File: tb/tb_onchip_memory_stream_reader.sv
// Scoreboard bench: stimulus pushes expected addresses and beats into queues,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_onchip_memory_stream_reader;
  import onchip_memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, st_ready;
  logic [17:0] base_addr;
  logic [18:0] length;
  logic        busy, done, avm_chipselect, avm_write, avm_clken;
  logic [17:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata, st_data;
  logic        st_valid, st_sop, st_eop;

  int n_vec = 0, n_err = 0, cyc = 0;
  int cs_count, beat_count, eop_count, done_count, busy_seen;
  int first_cs_cyc, last_beat_cyc, done_cyc, start_cyc;
  bit addr_chk = 1'b1;
  logic [17:0] addr_q [$];
  logic [33:0] beat_q [$];

  always #5 clk = ~clk;

  onchip_memory_stream_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .abort(abort), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_byteenable(avm_byteenable),
    .avm_clken(avm_clken), .avm_readdata(avm_readdata), .st_data(st_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop)
  );

  // Memory model: word contents equal the address, 1-cycle read latency.
  always @(posedge clk) begin
    avm_readdata <= avm_chipselect ? 32'(avm_address) : 32'hDEAD_BEEF;
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitor: read addresses, stream beats, done pulses.
  always @(negedge clk) begin
    if (avm_chipselect) begin
      cs_count++;
      if (first_cs_cyc < 0) first_cs_cyc = cyc;
      if (addr_chk) begin
        if (addr_q.size() == 0) flag("unexpected_read");
        else check("read_addr", 64'(avm_address), 64'(addr_q.pop_front()));
      end
    end
    if (st_valid && st_ready) begin
      beat_count++;
      last_beat_cyc = cyc;
      if (st_eop) eop_count++;
      if (beat_q.size() == 0) flag("unexpected_beat");
      else check("beat_sop_eop_data", 64'({st_sop, st_eop, st_data}), 64'(beat_q.pop_front()));
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
    if (busy) busy_seen = 1;
  end

  task automatic clear_stats();
    cs_count = 0; beat_count = 0; eop_count = 0; done_count = 0; busy_seen = 0;
    first_cs_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
  endtask

  // Queue expected addresses for len words and the first nbeats stream beats.
  task automatic expect_xfer(input int b, input int len, input int nbeats);
    for (int i = 0; i < len; i++) begin
      logic [17:0] a;
      a = 18'((b + i) % MEM_WORDS);
      addr_q.push_back(a);
      if (i < nbeats) beat_q.push_back({(i == 0), (i == len - 1), 32'(a)});
    end
  endtask

  task automatic issue_start(input int b, input int len);
    @(posedge clk); #1;
    base_addr = 18'(b); length = 19'(len); start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    bit found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    if (!found) flag("done_timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_beats(input int n, input int max);
    bit found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(posedge clk); #1;
      if (beat_count >= n) found = 1'b1;
    end
    if (!found) flag("beat_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; st_ready = 1'b1;
    base_addr = 18'd0; length = 19'd0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({busy, done, avm_chipselect, avm_address, st_valid, st_sop, st_eop}), 64'd0);
    check("const_outputs", 64'({avm_write, avm_byteenable, avm_clken}), 64'b0_1111_1);
    reset_n = 1'b1;

    // Basic 8-word packet with full throughput.
    clear_stats();
    expect_xfer(100, 8, 8);
    issue_start(100, 8);
    wait_done(40);
    repeat (2) @(posedge clk);
    #1;
    check("t1_beats", beat_count, 8);
    check("t1_reads", cs_count, 8);
    check("t1_latency", last_beat_cyc - first_cs_cyc, 9);
    check("t1_done_after_last", done_cyc - last_beat_cyc, 1);
    check("t1_done_count", done_count, 1);
    check("t1_queue_left", beat_q.size(), 0);

    // Address wrap at the top of memory.
    clear_stats();
    expect_xfer(MEM_WORDS - 2, 4, 4);
    issue_start(MEM_WORDS - 2, 4);
    wait_done(30);
    check("t2_beats", beat_count, 4);
    check("t2_queue_left", beat_q.size() + addr_q.size(), 0);

    // Backpressure: ready low for 10 cycles.
    clear_stats();
    st_ready = 1'b0;
    expect_xfer(300, 8, 8);
    issue_start(300, 8);
    repeat (9) @(posedge clk);
    #1;
    check("t3_stall_reads_le4", (cs_count <= 4), 1);
    check("t3_stall_head", 64'({st_valid, st_sop, st_eop, st_data}), {32'd0, 3'b110, 32'd300});
    st_ready = 1'b1;
    wait_done(40);
    check("t3_beats", beat_count, 8);
    check("t3_queue_left", beat_q.size() + addr_q.size(), 0);

    // Single-word packet.
    clear_stats();
    expect_xfer(42, 1, 1);
    issue_start(42, 1);
    wait_done(20);
    check("t4_beats", beat_count, 1);
    check("t4_eop_count", eop_count, 1);

    // Zero length: done next cycle, no reads, never busy.
    clear_stats();
    issue_start(5, 0);
    wait_done(10);
    repeat (3) @(posedge clk);
    #1;
    check("t5_done_cycle", done_cyc - start_cyc, 1);
    check("t5_reads", cs_count, 0);
    check("t5_done_count", done_count, 1);
    check("t5_busy_seen", busy_seen, 0);

    // Abort after 5 beats.
    clear_stats();
    addr_chk = 1'b0;
    expect_xfer(500, 16, 5);
    addr_q.delete();
    issue_start(500, 16);
    wait_beats(5, 30);
    abort = 1'b1; st_ready = 1'b0;
    #1;
    check("t6_cs_on_abort", avm_chipselect, 1'b0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("t6_after_abort", 64'({st_valid, done, busy}), 64'b010);
    @(posedge clk); #1;
    check("t6_done_width", done, 1'b0);
    st_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t6_eop_count", eop_count, 0);
    check("t6_done_count", done_count, 1);
    check("t6_beats", beat_count, 5);
    check("t6_queue_left", beat_q.size(), 0);
    addr_chk = 1'b1;

    // Normal start after abort.
    clear_stats();
    expect_xfer(7, 3, 3);
    issue_start(7, 3);
    wait_done(20);
    check("t7_beats", beat_count, 3);
    check("t7_queue_left", beat_q.size() + addr_q.size(), 0);

    // Reset in the middle of a transfer.
    clear_stats();
    expect_xfer(1000, 16, 16);
    issue_start(1000, 16);
    wait_beats(3, 20);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("t8_reset_outputs", 64'({busy, done, avm_chipselect, avm_address, st_valid, st_sop, st_eop}), 64'd0);
    addr_q.delete();
    beat_q.delete();
    done_count = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t8_no_done", done_count, 0);
    check("t8_idle", 64'({busy, st_valid}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
